// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Line states as {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // Bit timer width, enough for BIT_PERIOD up to 16
  localparam int unsigned TMR_W = 4;

  // NRZI: a 0 toggles J/K, a 1 holds the line
  function automatic logic [1:0] nrzi(input logic [1:0] line, input logic b);
    if (b) return line;
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_serializer_if.sv
// Byte handshake between the TX packet controller and the serializer.
interface usb_tx_serializer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       data_valid;
  logic       data_ready;

  modport master (output tx_start, tx_data, tx_last, data_valid, input data_ready);
  modport slave  (input tx_start, tx_data, tx_last, data_valid, output data_ready);
endinterface

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag_c
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  // Next count: clear wins, otherwise wrap at rollover_val
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + NUM_CNT_BITS'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_out       = count_q;
  assign rollover_flag_c = (count_q == rollover_val);

endmodule

// File: rtl/usb_tx_serializer.sv
// USB FS transmit serializer: SYNC, bit stuffing, NRZI, EOP on d_plus/d_minus.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 8,
  parameter int unsigned STUFF_LEN  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  usb_tx_serializer_if.slave   bus,
  output logic                 d_plus,
  output logic                 d_minus,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_error
);

  tx_state_t        state_q, state_d, ret_q, ret_d;
  logic [7:0]       sr_q, sr_d, hold_q, hold_d;
  logic [2:0]       idx_q, idx_d, ones_q, ones_d;
  logic [1:0]       line_q, line_d;
  logic             last_q, last_d, hold_last_q, hold_last_d, have_q, have_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [TMR_W-1:0] timer;
  logic             roll_c, wrap, xfer;
  logic             go_next, send, bit_v, load, load_last;
  logic [7:0]       load_byte;
  logic [2:0]       ones_base;

  // Bit timer runs whenever a packet is on the wire
  flex_counter #(.NUM_CNT_BITS(TMR_W)) u_bit_timer (
    .clk            (clk),
    .rst            (rst),
    .clear          (state_q == IDLE),
    .count_enable   (state_q != IDLE),
    .rollover_val   (TMR_W'(BIT_PERIOD - 1)),
    .count_out      (timer),
    .rollover_flag_c(roll_c)
  );

  assign wrap = roll_c && (state_q != IDLE);
  assign xfer = bus.data_valid && ready_q;

  // Next-state, shift path, line encoding and handshake
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    sr_d        = sr_q;
    idx_d       = idx_q;
    ones_d      = ones_q;
    line_d      = line_q;
    last_d      = last_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    have_d      = have_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    go_next     = 1'b0;
    send        = 1'b0;
    bit_v       = 1'b0;
    load        = 1'b0;
    load_byte   = hold_q;
    load_last   = hold_last_q;
    ones_base   = ones_q;

    if (xfer) begin
      hold_d      = bus.tx_data;
      hold_last_d = bus.tx_last;
      have_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        line_d = LINE_J;
        if (bus.tx_start) begin
          state_d   = SYNC;
          sr_d      = SYNC_BYTE;
          idx_d     = 3'd0;
          last_d    = 1'b0;
          have_d    = 1'b0;
          ones_base = 3'd0;
          send      = 1'b1;
          bit_v     = SYNC_BYTE[0];
        end
      end
      SYNC, DATA: begin
        if (wrap) begin
          if (ones_q == 3'(STUFF_LEN)) begin
            state_d = STUFF;
            ret_d   = state_q;
            line_d  = nrzi(line_q, 1'b0);
            ones_d  = 3'd0;
          end else begin
            go_next = 1'b1;
          end
        end
      end
      STUFF: begin
        if (wrap) go_next = 1'b1;
      end
      EOP_SE0: begin
        if (wrap) begin
          if (idx_q == 3'd0) begin
            idx_d = 3'd1;
          end else begin
            state_d = EOP_J;
            line_d  = LINE_J;
          end
        end
      end
      EOP_J: begin
        if (timer == TMR_W'(BIT_PERIOD - 2)) done_d = 1'b1;
        if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Advance to the next bit of the byte, or cross the byte boundary
    if (go_next) begin
      if (idx_q != 3'd7) begin
        state_d = (state_q == STUFF) ? ret_q : state_q;
        idx_d   = idx_q + 3'd1;
        sr_d    = {1'b0, sr_q[7:1]};
        send    = 1'b1;
        bit_v   = sr_q[1];
      end else if (last_q) begin
        state_d = EOP_SE0;
        idx_d   = 3'd0;
        line_d  = LINE_SE0;
      end else if (xfer) begin
        load      = 1'b1;
        load_byte = bus.tx_data;
        load_last = bus.tx_last;
      end else if (have_q) begin
        load = 1'b1;
      end else begin
        err_d   = 1'b1;
        state_d = EOP_SE0;
        idx_d   = 3'd0;
        line_d  = LINE_SE0;
      end
    end

    if (load) begin
      state_d = DATA;
      idx_d   = 3'd0;
      sr_d    = load_byte;
      last_d  = load_last;
      have_d  = 1'b0;
      send    = 1'b1;
      bit_v   = load_byte[0];
    end

    // Put a data bit on the line and track the run of 1s
    if (send) begin
      line_d = nrzi(line_q, bit_v);
      if (!bit_v)                         ones_d = 3'd0;
      else if (ones_base == 3'(STUFF_LEN)) ones_d = ones_base;
      else                                ones_d = ones_base + 3'd1;
    end

    ready_d = (state_d inside {SYNC, DATA, STUFF}) && (idx_d == 3'd7) && !last_d && !have_d;
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      sr_q        <= '0;
      idx_q       <= '0;
      ones_q      <= '0;
      line_q      <= LINE_J;
      last_q      <= 1'b0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      have_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      ones_q      <= ones_d;
      line_q      <= line_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      have_q      <= have_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.data_ready = ready_q;
  assign d_plus         = line_q[1];
  assign d_minus        = line_q[0];
  assign tx_busy        = busy_q;
  assign tx_done        = done_q;
  assign tx_error       = err_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer with a per-bit line scoreboard.
module tb_usb_tx_serializer;
  import usb_tx_pkg::*;

  localparam int unsigned BP = 8;

  logic clk = 1'b0;
  logic rst;
  logic d_plus, d_minus, tx_busy, tx_done, tx_error;

  always #5 clk = ~clk;

  usb_tx_serializer_if bus();

  usb_tx_serializer #(.BIT_PERIOD(BP), .STUFF_LEN(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .d_plus  (d_plus),
    .d_minus (d_minus),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_error(tx_error)
  );

  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;
  logic [1:0] exp_q[$];
  logic [7:0] pkt[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Expected line state per bit: SYNC, n bytes with stuffing, SE0 SE0 J
  task automatic model(input int n);
    logic [1:0] ln;
    logic [7:0] b;
    int         ones;
    exp_q.delete();
    ln   = LINE_J;
    ones = 0;
    for (int k = -1; k < n; k++) begin
      b = (k < 0) ? 8'h80 : pkt[k];
      for (int i = 0; i < 8; i++) begin
        if (b[i]) ones++;
        else begin
          ones = 0;
          ln   = (ln == LINE_J) ? LINE_K : LINE_J;
        end
        exp_q.push_back(ln);
        if (ones == 6) begin
          ones = 0;
          ln   = (ln == LINE_J) ? LINE_K : LINE_J;
          exp_q.push_back(ln);
        end
      end
    end
    exp_q.push_back(LINE_SE0);
    exp_q.push_back(LINE_SE0);
    exp_q.push_back(LINE_J);
  endtask

  // Send a packet of n bytes, feeding only nfeed; later bytes wait vdelay ready cycles
  task automatic send_packet(input int n, input int nfeed, input int vdelay, input bit poke);
    int         c, fi, total, err_c, rdy;
    logic [1:0] cur;
    bit         pend, done_seen;
    model(nfeed);
    total = exp_q.size() * BP;
    @(negedge clk);
    chk("idle_line", 32'({d_plus, d_minus}), 32'(LINE_J));
    chk("idle_busy", 32'(tx_busy), 32'd0);
    bus.tx_start   = 1'b1;
    bus.data_valid = (nfeed > 0);
    bus.tx_data    = pkt[0];
    bus.tx_last    = (n == 1);
    c = 0; fi = 0; err_c = 0; rdy = 0; pend = 0; done_seen = 0; cur = 2'bxx;
    while (!done_seen && c < 4000) begin
      @(negedge clk);
      c++;
      bus.tx_start = poke && (c == 3);
      if (pend) begin
        chk("ready_drop", 32'(bus.data_ready), 32'd0);
        fi++;
        rdy = 0;
        if (fi < nfeed) begin
          bus.tx_data = pkt[fi];
          bus.tx_last = (fi == n - 1);
        end
        bus.data_valid = (fi < nfeed) && (vdelay == 0);
      end
      if (!bus.data_valid && fi < nfeed && bus.data_ready) begin
        rdy++;
        if (rdy >= vdelay) bus.data_valid = 1'b1;
      end
      pend = bus.data_ready && bus.data_valid;
      if ((c - 1) % BP == 0) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      chk("line", 32'({d_plus, d_minus}), 32'(cur));
      chk("busy", 32'(tx_busy), 32'd1);
      if (tx_error) begin
        err_c++;
        chk("err_time", 32'(c), 32'(total - 3 * BP + 1));
      end
      if (tx_done) done_seen = 1;
    end
    bus.tx_start   = 1'b0;
    bus.data_valid = 1'b0;
    chk("done_cycle", 32'(c), 32'(total));
    chk("err_count", 32'(err_c), 32'(nfeed < n));
    chk("bytes_fed", 32'(fi), 32'(nfeed));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int dcnt;
    rst            = 1'b1;
    bus.tx_start   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.tx_last    = 1'b0;
    bus.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset for 2 cycles in idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_dp", 32'(d_plus), 32'd1);
    chk("rst_dm", 32'(d_minus), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_ready", 32'(bus.data_ready), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_error), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 00 byte: 152 clocks, then back-to-back FF with an ignored start in SYNC: 160 clocks
    pkt[0] = 8'h00;
    send_packet(1, 1, 0, 1'b0);
    pkt[0] = 8'hFF;
    send_packet(1, 1, 0, 1'b1);

    // Stuff at a byte boundary stalls ready; byte accepted inside the stall
    pkt[0] = 8'hFC; pkt[1] = 8'h01;
    send_packet(2, 2, BP + 3, 1'b0);

    // Stuff after the final data bit is still sent before EOP
    pkt[0] = 8'h01; pkt[1] = 8'hFC;
    send_packet(2, 2, 0, 1'b0);

    // Three bytes with transfers landing on the boundary cycle
    pkt[0] = 8'hFF; pkt[1] = 8'hFF; pkt[2] = 8'h00;
    send_packet(3, 3, BP, 1'b0);

    // Underrun: second byte withheld
    pkt[0] = 8'hA5; pkt[1] = 8'h3C;
    send_packet(2, 1, 0, 1'b0);

    // Reset during the 3rd data bit
    @(negedge clk);
    bus.tx_start   = 1'b1;
    bus.tx_data    = 8'h00;
    bus.tx_last    = 1'b1;
    bus.data_valid = 1'b1;
    for (int c = 1; c <= 10 * BP + 3; c++) begin
      @(negedge clk);
      bus.tx_start = 1'b0;
      if (c > 9 * BP) bus.data_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_line", 32'({d_plus, d_minus}), 32'(LINE_J));
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.data_ready), 32'd0);
    chk("mid_rst_done", 32'(tx_done), 32'd0);
    dcnt = 0;
    for (int c = 0; c < 20 * BP; c++) begin
      @(negedge clk);
      if (tx_done || tx_busy || {d_plus, d_minus} != LINE_J) dcnt++;
    end
    chk("post_rst_quiet", 32'(dcnt), 32'd0);

    // Normal packet after the aborted one
    pkt[0] = 8'h5A;
    send_packet(1, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
